button_debouncer_array: RTL

Parametrised multi-channel push-button conditioner for the FPGA side of the HPS-FPGA base design. For each channel it synchronises a raw key/switch input, debounces it with a configurable stable-time, and produces a clean level, one-cycle press/release pulses, and long-press / auto-repeat pulses. It sits between board KEY/SW pins and control FSMs or HPS-visible status registers.

---
 rtl/button_debouncer_array.sv | 121 ++++++++++++
 1 files changed

// File: rtl/button_debouncer_array.sv
// button_debouncer_array
// Multi-channel push-button conditioner. Each channel synchronises a raw pin,
// debounces it, and produces a clean level, press/release pulses, and
// long-press / auto-repeat pulses. All outputs are registered.
module button_debouncer_array #(
  parameter int N_CH          = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long
);

  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s0;
    logic          s1;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          rep;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          differ;
    logic          accept;

    // Synchronised input disagrees with the accepted level; accept once the
    // disagreement has lasted DB_CYCLES consecutive cycles.
    assign differ = (s1 != level_q);
    assign accept = differ && (db_cnt == DB_LAST);

    // Two-flop synchroniser with polarity normalised to 1 = pressed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s0 <= 1'b0;
        s1 <= 1'b0;
      end else begin
        // NOTE: non-blocking so s1 takes the previous s0, forming two real stages.
        s0 <= btn_in[i] ^ POL;
        s1 <= s0;
      end
    end

    // Debounce: count consecutive disagreeing cycles, flip level and pulse on accept.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        // NOTE: pulses default low every cycle so they can only ever be one clk wide.
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (!differ) begin
          db_cnt <= '0;
        end else if (accept) begin
          level_q   <= s1;
          db_cnt    <= '0;
          press_q   <= s1;
          release_q <= ~s1;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
    end

    // Hold timer: first long pulse after HOLD_CYCLES, then every REPEAT_CYCLES.
    // A release accepted this cycle clears the timer and suppresses any pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_cnt <= '0;
        rep      <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!level_q || accept) begin
          hold_cnt <= '0;
          rep      <= 1'b0;
        end else if (!rep) begin
          if (hold_cnt == HOLD_LAST) begin
            long_q   <= 1'b1;
            hold_cnt <= '0;
            rep      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end else if (REPEAT_CYCLES > 0) begin
          if (hold_cnt == REP_LAST) begin
            long_q   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule
